pixel_stream_processor: RTL and testbench

Parametrised successor to the pixel data processor: a streaming per-pixel point-operation engine with full valid/ready handshake, a 2-stage pipeline, and frame/line tracking. Config registers are shadowed, so mode and coefficient changes take effect only on frame boundaries. It sits between the pixel producer and the output sink, with configuration over the simple register bus.

---
 rtl/pixel_stream_processor.sv | 229 ++++++++++++++++++++++
 tb/tb_pixel_stream_processor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_processor.sv
// Streaming per-pixel point-op engine (bypass/invert/threshold/offset/gain) with frame/line tagging and shadowed config.
// Latency: 2 cycles from input accept to out_data; 1 pixel/clk sustained.
// Backpressure: valid/ready; out_valid && !out_ready freezes both stages and drops in_ready. Optional PIXEL_STATS_EN adds per-frame min/max.
module pixel_stream_processor #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_eol,
   output logic                  out_eof,
   input  logic                  reg_write_en,
   input  logic [4:0]            reg_addr,
   input  logic [7:0]            reg_wdata,
   output logic [7:0]            reg_rdata
);

   localparam int K  = DATA_WIDTH - 8;
   localparam int EW = DATA_WIDTH + 6;
   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [DATA_WIDTH-1:0] MAX_VAL = '1;

   localparam logic [2:0] OP_BYPASS = 3'd0;
   localparam logic [2:0] OP_INVERT = 3'd1;
   localparam logic [2:0] OP_THRESH = 3'd2;
   localparam logic [2:0] OP_OFFSET = 3'd3;
   localparam logic [2:0] OP_GAIN   = 3'd4;

   // config: shadow (bus-visible) and active (used mid-frame)
   logic [2:0] shd_mode_q, shd_mode_d, act_mode_q, act_mode_d;
   logic [7:0] shd_thresh_q, shd_thresh_d, act_thresh_q, act_thresh_d;
   logic [7:0] shd_offset_q, shd_offset_d, act_offset_q, act_offset_d;
   logic [7:0] shd_gain_q, shd_gain_d, act_gain_q, act_gain_d;
   logic       enable_q, enable_d;

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          frame_done_q, frame_done_d;

   logic                  s1_vld_q, s1_vld_d, s1_eol_q, s1_eol_d, s1_eof_q, s1_eof_d;
   logic signed [EW-1:0]  s1_val_q, s1_val_d;
   logic                  out_vld_q, out_vld_d, out_eol_q, out_eol_d, out_eof_q, out_eof_d;
   logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;

   logic advance, accept, first_pix, last_col, last_row, clr_cnt, w1c_done, pending;
   logic [2:0] eff_mode;
   logic [7:0] eff_thresh, eff_offset, eff_gain;
   logic [DATA_WIDTH-1:0] thr_w, sat_val;
   logic [DATA_WIDTH+7:0] prod;
   logic signed [EW-1:0]  in_ext, off_ext, op_val;

   assign advance   = !out_vld_q || out_ready;
   assign in_ready  = advance && enable_q;
   assign accept    = in_valid && in_ready;
   assign first_pix = (col_q == '0) && (row_q == '0);
   assign last_col  = (col_q == CW'(IMG_WIDTH - 1));
   assign last_row  = (row_q == RW'(IMG_HEIGHT - 1));
   assign clr_cnt   = reg_write_en && (reg_addr == 5'h04) && reg_wdata[1];
   assign w1c_done  = reg_write_en && (reg_addr == 5'h10) && reg_wdata[2];
   assign pending   = (shd_mode_q != act_mode_q) || (shd_thresh_q != act_thresh_q) ||
                      (shd_offset_q != act_offset_q) || (shd_gain_q != act_gain_q);

   assign out_valid = out_vld_q;
   assign out_data  = out_dat_q;
   assign out_eol   = out_eol_q;
   assign out_eof   = out_eof_q;

   // Stage-1 operator: the first pixel of a frame sees the shadow config, later pixels the latched copy
   always_comb begin
      eff_mode   = first_pix ? shd_mode_q   : act_mode_q;
      eff_thresh = first_pix ? shd_thresh_q : act_thresh_q;
      eff_offset = first_pix ? shd_offset_q : act_offset_q;
      eff_gain   = first_pix ? shd_gain_q   : act_gain_q;
      thr_w      = DATA_WIDTH'(eff_thresh) << K;
      in_ext     = $signed(EW'(in_data));
      off_ext    = EW'($signed(eff_offset)) <<< K;
      prod       = (DATA_WIDTH+8)'(in_data) * (DATA_WIDTH+8)'(eff_gain);
      case (eff_mode)
         OP_BYPASS: op_val = in_ext;
         OP_INVERT: op_val = $signed(EW'(MAX_VAL - in_data));
         OP_THRESH: op_val = (in_data >= thr_w) ? $signed(EW'(MAX_VAL)) : '0;
         OP_OFFSET: op_val = in_ext + off_ext;
         OP_GAIN:   op_val = $signed(EW'(prod[DATA_WIDTH+7:4]));
         default:   op_val = '0;
      endcase
   end

   // Stage-2 saturation to [0, MAX]
   always_comb begin
      if (s1_val_q[EW-1])                       sat_val = '0;
      else if (|s1_val_q[EW-2:DATA_WIDTH])      sat_val = MAX_VAL;
      else                                      sat_val = s1_val_q[DATA_WIDTH-1:0];
   end

   // Next-state for pipeline, counters, status and config
   always_comb begin
      s1_vld_d = s1_vld_q;  s1_val_d = s1_val_q;  s1_eol_d = s1_eol_q;  s1_eof_d = s1_eof_q;
      out_vld_d = out_vld_q; out_dat_d = out_dat_q; out_eol_d = out_eol_q; out_eof_d = out_eof_q;
      if (advance) begin
         s1_vld_d  = accept;
         s1_val_d  = op_val;
         s1_eol_d  = accept && last_col;
         s1_eof_d  = accept && last_col && last_row;
         out_vld_d = s1_vld_q;
         out_dat_d = sat_val;
         out_eol_d = s1_eol_q;
         out_eof_d = s1_eof_q;
      end

      col_d = col_q; row_d = row_q; frame_cnt_d = frame_cnt_q; frame_done_d = frame_done_q;
      if (w1c_done) frame_done_d = 1'b0;
      if (accept) begin
         if (last_col) begin
            col_d = '0;
            if (last_row) begin
               row_d        = '0;
               frame_cnt_d  = frame_cnt_q + 16'd1;
               frame_done_d = 1'b1;
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end
      if (clr_cnt) begin
         col_d = '0; row_d = '0; frame_cnt_d = '0;
      end

      shd_mode_d = shd_mode_q; shd_thresh_d = shd_thresh_q; shd_offset_d = shd_offset_q;
      shd_gain_d = shd_gain_q; enable_d = enable_q;
      if (reg_write_en) begin
         case (reg_addr)
            5'h00:   shd_mode_d   = reg_wdata[2:0];
            5'h01:   shd_thresh_d = reg_wdata;
            5'h02:   shd_offset_d = reg_wdata;
            5'h03:   shd_gain_d   = reg_wdata;
            5'h04:   enable_d     = reg_wdata[0];
            default: ;
         endcase
      end

      // latch the pre-write shadow so a coincident write waits for the next frame
      act_mode_d = act_mode_q; act_thresh_d = act_thresh_q; act_offset_d = act_offset_q; act_gain_d = act_gain_q;
      if (accept && first_pix) begin
         act_mode_d = shd_mode_q; act_thresh_d = shd_thresh_q; act_offset_d = shd_offset_q; act_gain_d = shd_gain_q;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q <= 1'b0; s1_val_q <= '0; s1_eol_q <= 1'b0; s1_eof_q <= 1'b0;
         out_vld_q <= 1'b0; out_dat_q <= '0; out_eol_q <= 1'b0; out_eof_q <= 1'b0;
         col_q <= '0; row_q <= '0; frame_cnt_q <= '0; frame_done_q <= 1'b0;
         shd_mode_q <= '0; shd_thresh_q <= 8'h80; shd_offset_q <= '0; shd_gain_q <= 8'h10;
         act_mode_q <= '0; act_thresh_q <= 8'h80; act_offset_q <= '0; act_gain_q <= 8'h10;
         enable_q <= 1'b1;
      end else begin
         s1_vld_q <= s1_vld_d; s1_val_q <= s1_val_d; s1_eol_q <= s1_eol_d; s1_eof_q <= s1_eof_d;
         out_vld_q <= out_vld_d; out_dat_q <= out_dat_d; out_eol_q <= out_eol_d; out_eof_q <= out_eof_d;
         col_q <= col_d; row_q <= row_d; frame_cnt_q <= frame_cnt_d; frame_done_q <= frame_done_d;
         shd_mode_q <= shd_mode_d; shd_thresh_q <= shd_thresh_d; shd_offset_q <= shd_offset_d; shd_gain_q <= shd_gain_d;
         act_mode_q <= act_mode_d; act_thresh_q <= act_thresh_d; act_offset_q <= act_offset_d; act_gain_q <= act_gain_d;
         enable_q <= enable_d;
      end
   end

`ifdef PIXEL_STATS_EN
   logic [7:0] trk_min_q, trk_min_d, trk_max_q, trk_max_d, st_min_q, st_min_d, st_max_q, st_max_d;
   logic [7:0] out_top, cur_min, cur_max;

   // Per-frame min/max of the top byte, published when the eof pixel leaves
   always_comb begin
      out_top   = out_dat_q[DATA_WIDTH-1 -: 8];
      cur_min   = (out_top < trk_min_q) ? out_top : trk_min_q;
      cur_max   = (out_top > trk_max_q) ? out_top : trk_max_q;
      trk_min_d = trk_min_q; trk_max_d = trk_max_q; st_min_d = st_min_q; st_max_d = st_max_q;
      if (out_vld_q && out_ready) begin
         if (out_eof_q) begin
            st_min_d = cur_min; st_max_d = cur_max;
            trk_min_d = 8'hFF;  trk_max_d = 8'h00;
         end else begin
            trk_min_d = cur_min; trk_max_d = cur_max;
         end
      end
   end

   // Stats registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trk_min_q <= 8'hFF; trk_max_q <= 8'h00; st_min_q <= 8'h00; st_max_q <= 8'h00;
      end else begin
         trk_min_q <= trk_min_d; trk_max_q <= trk_max_d; st_min_q <= st_min_d; st_max_q <= st_max_d;
      end
   end
`endif

   // Register read mux; config reads return the shadow copies
   always_comb begin
      reg_rdata = 8'h00;
      case (reg_addr)
         5'h00:   reg_rdata = {5'b0, shd_mode_q};
         5'h01:   reg_rdata = shd_thresh_q;
         5'h02:   reg_rdata = shd_offset_q;
         5'h03:   reg_rdata = shd_gain_q;
         5'h04:   reg_rdata = {7'b0, enable_q};
         5'h10:   reg_rdata = {5'b0, frame_done_q, pending, !first_pix};
         5'h11:   reg_rdata = 8'hA2;
         5'h12:   reg_rdata = frame_cnt_q[7:0];
         5'h13:   reg_rdata = frame_cnt_q[15:8];
`ifdef PIXEL_STATS_EN
         5'h14:   reg_rdata = st_min_q;
         5'h15:   reg_rdata = st_max_q;
`endif
         default: reg_rdata = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_pixel_stream_processor.sv
// Directed bench for pixel_stream_processor: vector table for the point ops plus
// hand-written sequences for latency, stall, frame tracking, shadowing and reset.
module tb_pixel_stream_processor;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, out_eol, out_eof;
   logic [7:0] in_data, out_data;
   logic       reg_write_en;
   logic [4:0] reg_addr;
   logic [7:0] reg_wdata, reg_rdata;

   int checks = 0;
   int errors = 0;

   pixel_stream_processor #(.DATA_WIDTH(8), .IMG_WIDTH(32), .IMG_HEIGHT(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_eol(out_eol), .out_eof(out_eof),
      .reg_write_en(reg_write_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [2:0] mode;
      logic [7:0] thr, off, gain, din, dout;
   } vec_t;
   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input string n, input logic [2:0] m, input logic [7:0] t, input logic [7:0] o,
                      input logic [7:0] g, input logic [7:0] di, input logic [7:0] dq);
      vec_t v;
      v.name = n; v.mode = m; v.thr = t; v.off = o; v.gain = g; v.din = di; v.dout = dq;
      vq.push_back(v);
   endtask

   task automatic reg_wr(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      reg_write_en = 1'b1; reg_addr = a; reg_wdata = d;
      @(negedge clk);
      reg_write_en = 1'b0; reg_addr = 5'h10;
   endtask

   task automatic reg_chk(input string name, input logic [4:0] a, input logic [7:0] exp);
      @(negedge clk);
      reg_addr = a;
      #1 chk(name, reg_rdata, exp);
   endtask

   // one isolated pixel: wait for in_ready (bounded), then expect it on the output 2 edges later
   task automatic send_check(input string name, input logic [7:0] d, input logic [7:0] exp);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; out_ready = 1'b1;
      #1 n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk); #1 n++;
      end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk({name, "_lat1"}, out_valid, 1'b0);
      @(negedge clk);
      chk(name, {out_valid, out_data}, {1'b1, exp});
   endtask

   function automatic logic [7:0] pixv(input int i);
      return (i < 1024) ? 8'(5 + (i * 7) % 220) : 8'h37;
   endfunction

   logic [7:0] p3 [3];
   logic [7:0] held_d;
   logic       held_eol, held_eof, stall_prev, wrote;
   int idx, oidx, cyc, bad_dat, bad_flag, bad_stab, bad_pend;
   logic [7:0] exp_d;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      reg_write_en = 1'b0; reg_addr = 5'h10; reg_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_outs", {out_valid, out_data, out_eol, out_eof}, 11'h0);
      rst = 1'b0;

      // reset defaults and ID
      reg_chk("id", 5'h11, 8'hA2);
      reg_chk("mode_def", 5'h00, 8'h00);
      reg_chk("thresh_def", 5'h01, 8'h80);
      reg_chk("gain_def", 5'h03, 8'h10);
      reg_chk("ctrl_def", 5'h04, 8'h01);
      reg_chk("status_def", 5'h10, 8'h00);
      reg_chk("unmapped", 5'h1F, 8'h00);

      // back-to-back bypass stream, 2-cycle latency at full rate
      p3[0] = 8'h00; p3[1] = 8'h37; p3[2] = 8'hFF;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         if (c >= 2) chk($sformatf("b2b_%0d", c - 2), {out_valid, out_data}, {1'b1, p3[c-2]});
         else        chk($sformatf("b2b_empty_%0d", c), out_valid, 1'b0);
         in_valid = (c < 3); in_data = (c < 3) ? p3[c] : 8'h00;
      end
      in_valid = 1'b0;

      // disable: pixel accepted in the write cycle drains, then in_ready stays low
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h5A; reg_write_en = 1'b1; reg_addr = 5'h04; reg_wdata = 8'h00;
      @(negedge clk);
      reg_write_en = 1'b0; reg_addr = 5'h10;
      #1 chk("dis_in_ready", in_ready, 1'b0);
      @(negedge clk);
      chk("dis_drain", {out_valid, out_data}, {1'b1, 8'h5A});
      @(negedge clk);
      chk("dis_no_accept", out_valid, 1'b0);
      in_valid = 1'b0;
      reg_wr(5'h04, 8'h01);

      // point-op table; CTRL.clear_counters puts each vector at a frame start
      add("byp_37",  3'd0, 8'h80, 8'h00, 8'h10, 8'h37, 8'h37);
      add("inv_37",  3'd1, 8'h80, 8'h00, 8'h10, 8'h37, 8'hC8);
      add("inv_00",  3'd1, 8'h80, 8'h00, 8'h10, 8'h00, 8'hFF);
      add("thr_eq",  3'd2, 8'h80, 8'h00, 8'h10, 8'h80, 8'hFF);
      add("thr_lo",  3'd2, 8'h80, 8'h00, 8'h10, 8'h7F, 8'h00);
      add("off_sat", 3'd3, 8'h80, 8'h40, 8'h10, 8'hF0, 8'hFF);
      add("off_neg", 3'd3, 8'h80, 8'hC0, 8'h10, 8'h20, 8'h00);
      add("off_mid", 3'd3, 8'h80, 8'h10, 8'h10, 8'h20, 8'h30);
      add("gain_15", 3'd4, 8'h80, 8'h00, 8'h18, 8'h80, 8'hC0);
      add("gain_sat",3'd4, 8'h80, 8'h00, 8'h18, 8'hC0, 8'hFF);
      add("gain_05", 3'd4, 8'h80, 8'h00, 8'h08, 8'h81, 8'h40);
      add("mode5",   3'd5, 8'h80, 8'h00, 8'h10, 8'h55, 8'h00);
      add("mode7",   3'd7, 8'h80, 8'h00, 8'h10, 8'hAA, 8'h00);
      foreach (vq[i]) begin
         reg_wr(5'h00, {5'b0, vq[i].mode});
         reg_wr(5'h01, vq[i].thr);
         reg_wr(5'h02, vq[i].off);
         reg_wr(5'h03, vq[i].gain);
         reg_wr(5'h04, 8'h03);
         send_check(vq[i].name, vq[i].din, vq[i].dout);
      end
      reg_chk("off_readback", 5'h02, 8'h00);
      reg_chk("ctrl_clr_reads0", 5'h04, 8'h01);

      // full frame in bypass under random backpressure, MODE=1 written at pixel 10
      reg_wr(5'h00, 8'h00);
      reg_wr(5'h03, 8'h10);
      reg_wr(5'h04, 8'h03);
      idx = 0; oidx = 0; cyc = 0; wrote = 1'b0; stall_prev = 1'b0;
      bad_dat = 0; bad_flag = 0; bad_stab = 0; bad_pend = 0;
      held_d = '0; held_eol = 1'b0; held_eof = 1'b0;
      while (oidx < 1025 && cyc < 8000) begin
         @(negedge clk);
         if (stall_prev && (out_valid !== 1'b1 || out_data !== held_d || out_eol !== held_eol || out_eof !== held_eof))
            bad_stab++;
         if (!reg_write_en && idx >= 1 && reg_rdata[1] !== (wrote && idx <= 1024))
            bad_pend++;
         if (reg_write_en) begin
            reg_write_en = 1'b0; reg_addr = 5'h10; wrote = 1'b1;
         end
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (idx < 1025);
         in_data   = pixv(idx);
         if (idx == 10 && !wrote && !reg_write_en) begin
            reg_write_en = 1'b1; reg_addr = 5'h00; reg_wdata = 8'h01;
         end
         #1;
         if (out_valid && out_ready) begin
            exp_d = (oidx < 1024) ? pixv(oidx) : 8'hC8;
            if (out_data !== exp_d) bad_dat++;
            if (out_eol !== (oidx < 1024 && oidx % 32 == 31) || out_eof !== (oidx == 1023)) bad_flag++;
            oidx++;
         end
         stall_prev = out_valid && !out_ready;
         held_d = out_data; held_eol = out_eol; held_eof = out_eof;
         if (in_valid && in_ready) idx++;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("frame_out_count", oidx, 1025);
      chk("frame_data_errs", bad_dat, 0);
      chk("frame_eol_eof_errs", bad_flag, 0);
      chk("stall_stable_errs", bad_stab, 0);
      chk("pending_errs", bad_pend, 0);
      reg_chk("frame_cnt_lo", 5'h12, 8'h01);
      reg_chk("frame_cnt_hi", 5'h13, 8'h00);
      reg_chk("status_done", 5'h10, 8'h05);
      reg_wr(5'h10, 8'h04);
      reg_chk("status_w1c", 5'h10, 8'h01);
`ifdef PIXEL_STATS_EN
      reg_chk("stat_min", 5'h14, 8'h05);
      reg_chk("stat_max", 5'h15, 8'hE0);
`else
      reg_chk("stat_min", 5'h14, 8'h00);
      reg_chk("stat_max", 5'h15, 8'h00);
`endif

      // reset with two pixels in flight
      reg_wr(5'h01, 8'h22);
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h11;
      @(negedge clk);
      in_data = 8'h22;
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1'b1);
      rst = 1'b1;
      #1 chk("rst_async_outs", {out_valid, out_data, out_eol, out_eof}, 11'h0);
      @(negedge clk);
      rst = 1'b0;
      reg_chk("rst_mode", 5'h00, 8'h00);
      reg_chk("rst_thresh", 5'h01, 8'h80);
      reg_chk("rst_status", 5'h10, 8'h00);
      reg_chk("rst_frame_cnt", 5'h12, 8'h00);
      @(negedge clk);
      chk("rst_flushed", out_valid, 1'b0);
      send_check("post_rst_byp", 8'h37, 8'h37);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
